// File: rtl/axi_sram_rd_slave.sv
// axi_sram_rd_slave: AXI read-data responder backed by a single-port synchronous SRAM.
//
// Accepts one AR request at a time and returns a burst on the R channel. Each beat takes
// a FETCH cycle, which drives the SRAM address, and then a RESP cycle, which presents the
// SRAM output on rdata_o. The slave-side ID is echoed unchanged.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   ar*_i / arready_o  read-address channel (arsize_i is accepted but not checked)
//   r*_o / rready_i    read-data channel
//   sram_*_o           SRAM chip select, output enable and word address
//   sram_do_i          SRAM read data, valid the cycle after the address is sampled

module axi_sram_rd_slave #(
    parameter int unsigned AXI_IDS_BITS   = 8,
    parameter int unsigned AXI_ADDR_BITS  = 32,
    parameter int unsigned AXI_DATA_BITS  = 32,
    parameter int unsigned AXI_LEN_BITS   = 4,
    parameter int unsigned SRAM_ADDR_BITS = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    // AR channel
    input  logic [AXI_IDS_BITS-1:0]   arid_i,
    input  logic [AXI_ADDR_BITS-1:0]  araddr_i,
    input  logic [AXI_LEN_BITS-1:0]   arlen_i,
    input  logic [2:0]                arsize_i,
    input  logic [1:0]                arburst_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    // R channel
    output logic [AXI_IDS_BITS-1:0]   rid_o,
    output logic [AXI_DATA_BITS-1:0]  rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rlast_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    // SRAM
    output logic                      sram_cs_o,
    output logic                      sram_oe_o,
    output logic [SRAM_ADDR_BITS-1:0] sram_a_o,
    input  logic [AXI_DATA_BITS-1:0]  sram_do_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;

    localparam logic [1:0] BurstFixed = 2'b00;

    logic [1:0]                state_q, state_d;
    logic [AXI_IDS_BITS-1:0]   id_q, id_d;
    logic [SRAM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [AXI_LEN_BITS-1:0]   len_q, len_d;
    logic [1:0]                burst_q, burst_d;
    logic [AXI_LEN_BITS-1:0]   cnt_q, cnt_d;

    logic last_beat;

    // Address bits outside the SRAM word range and the size field are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{araddr_i[AXI_ADDR_BITS-1:SRAM_ADDR_BITS+2], araddr_i[1:0],
                             arsize_i};

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (arvalid_i) begin
                    id_d    = arid_i;
                    addr_d  = araddr_i[SRAM_ADDR_BITS+1:2];
                    len_d   = arlen_i;
                    burst_d = arburst_i;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StResp;
            end
            StResp: begin
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d   = cnt_q + AXI_LEN_BITS'(1);
                        // WRAP and reserved bursts are read with INCR addressing.
                        if (burst_q != BurstFixed) begin
                            addr_d = addr_q + SRAM_ADDR_BITS'(1);
                        end
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        rlast_o   = 1'b0;
        rid_o     = '0;
        rdata_o   = '0;
        rresp_o   = 2'b00;
        sram_cs_o = 1'b0;
        sram_oe_o = 1'b0;
        case (state_q)
            StIdle: begin
                arready_o = 1'b1;
            end
            StFetch: begin
                sram_cs_o = 1'b1;
                sram_oe_o = 1'b1;
            end
            StResp: begin
                sram_cs_o = 1'b1;
                sram_oe_o = 1'b1;
                rvalid_o  = 1'b1;
                rlast_o   = last_beat;
                rid_o     = id_q;
                rdata_o   = sram_do_i;
                // burst 1x (WRAP or reserved) answers SLVERR on every beat.
                rresp_o   = burst_q[1] ? 2'b10 : 2'b00;
            end
            default: begin
                arready_o = 1'b0;
            end
        endcase
    end

    // The address register drives the SRAM directly, so it holds outside a burst.
    assign sram_a_o = addr_q;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Self-checking bench for axi_sram_rd_slave: table-driven directed bursts, hand-written
// reset and back-to-back sequences, then randomized bursts against a reference model.

module tb_axi_sram_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  arid_i = '0;
    logic [31:0] araddr_i = '0;
    logic [3:0]  arlen_i = '0;
    logic [2:0]  arsize_i = 3'b010;
    logic [1:0]  arburst_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [7:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic        sram_cs_o;
    logic        sram_oe_o;
    logic [13:0] sram_a_o;
    logic [31:0] sram_do_i = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    // Synchronous SRAM: data appears the cycle after the address is sampled.
    always @(posedge clk) begin
        if (sram_cs_o && sram_oe_o) sram_do_i <= mem[sram_a_o];
    end

    axi_sram_rd_slave dut (
        .clk       (clk),
        .rst       (rst),
        .arid_i    (arid_i),
        .araddr_i  (araddr_i),
        .arlen_i   (arlen_i),
        .arsize_i  (arsize_i),
        .arburst_i (arburst_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rid_o     (rid_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rlast_o   (rlast_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .sram_cs_o (sram_cs_o),
        .sram_oe_o (sram_oe_o),
        .sram_a_o  (sram_a_o),
        .sram_do_i (sram_do_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: word address of beat k is the start word plus k (FIXED: plus 0), mod 16K.
    function automatic logic [13:0] word_of(input logic [31:0] addr, input logic [1:0] burst,
                                            input int k);
        int w;
        w = int'(addr[15:2]) + ((burst == 2'b00) ? 0 : k);
        return 14'(w % 16384);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [13:0] exp_a);
        chk({tag, "_arready"}, 64'(arready_o), 64'd1);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd0);
        chk({tag, "_rlast"}, 64'(rlast_o), 64'd0);
        chk({tag, "_cs_oe"}, 64'({sram_cs_o, sram_oe_o}), 64'd0);
        chk({tag, "_rid_rdata_rresp"}, 64'({rid_o, rdata_o, rresp_o}), 64'd0);
        chk({tag, "_sram_a"}, 64'(sram_a_o), 64'(exp_a));
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] id, input logic [13:0] w,
                            input logic [1:0] resp, input logic last);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 64'd1);
        chk({tag, "_rid"}, 64'(rid_o), 64'(id));
        chk({tag, "_rdata"}, 64'(rdata_o), 64'(mem[w]));
        chk({tag, "_rresp"}, 64'(rresp_o), 64'(resp));
        chk({tag, "_rlast"}, 64'(rlast_o), 64'(last));
        chk({tag, "_sram_a"}, 64'(sram_a_o), 64'(w));
        chk({tag, "_cs_oe"}, 64'({sram_cs_o, sram_oe_o}), 64'd3);
        chk({tag, "_arready"}, 64'(arready_o), 64'd0);
    endtask

    // Issues one AR at the start of an idle cycle and consumes the full burst.
    task automatic do_burst(input string tag, input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst,
                            input int stall_beat, input int stall_cyc, input bit rnd_stall,
                            input logic [13:0] exp_first);
        logic [13:0] w;
        logic [1:0]  resp;
        int          stalls;
        resp      = burst[1] ? 2'b10 : 2'b00;
        arid_i    = id;
        araddr_i  = addr;
        arlen_i   = len;
        arburst_i = burst;
        arvalid_i = 1'b1;
        chk({tag, "_ar_ready"}, 64'(arready_o), 64'd1);
        cyc();
        arvalid_i = 1'b0;
        chk({tag, "_first_a"}, 64'(sram_a_o), 64'(exp_first));
        w = '0;
        for (int k = 0; k <= int'(len); k++) begin
            w = word_of(addr, burst, k);
            chk({tag, "_fetch_rvalid"}, 64'(rvalid_o), 64'd0);
            chk({tag, "_fetch_cs"}, 64'(sram_cs_o), 64'd1);
            chk({tag, "_fetch_arready"}, 64'(arready_o), 64'd0);
            chk({tag, "_fetch_a"}, 64'(sram_a_o), 64'(w));
            cyc();
            if (k == stall_beat) stalls = stall_cyc;
            else if (rnd_stall) stalls = int'($urandom_range(0, 2));
            else stalls = 0;
            for (int s = 0; s <= stalls; s++) begin
                chk_beat({tag, "_beat"}, id, w, resp, (k == int'(len)));
                rready_i = (s == stalls);
                cyc();
                rready_i = 1'b0;
            end
        end
        chk_idle({tag, "_after"}, w);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          stall_beat;
        int          stall_cyc;
        logic [13:0] exp_first;
    } vec_t;

    vec_t vecs [6];

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[14'h10] = 32'hDEADBEEF;

        vecs[0] = '{"single",   8'h13, 32'h0000_0040, 4'd0, 2'b01, -1, 0, 14'h0010};
        vecs[1] = '{"incr4",    8'h21, 32'h0000_0100, 4'd3, 2'b01,  1, 3, 14'h0040};
        vecs[2] = '{"fixed",    8'h35, 32'h0000_0020, 4'd2, 2'b00, -1, 0, 14'h0008};
        vecs[3] = '{"wraparnd", 8'h4A, 32'h0000_FFF8, 4'd2, 2'b01, -1, 0, 14'h3FFE};
        vecs[4] = '{"wrapburst", 8'h5C, 32'h0000_1234, 4'd1, 2'b10, 0, 2, 14'h048D};
        vecs[5] = '{"reserved", 8'h6E, 32'hABCD_0010, 4'd2, 2'b11, -1, 0, 14'h0004};

        // Reset state
        #12;
        chk_idle("reset", 14'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        chk_idle("post_reset", 14'h0);

        // Spot checks from hand-derived values, independent of the model
        arid_i = 8'h13; araddr_i = 32'h40; arlen_i = 4'd0; arburst_i = 2'b01; arvalid_i = 1'b1;
        cyc();
        arvalid_i = 1'b0;
        cyc();
        chk("single_rdata_const", 64'(rdata_o), 64'hDEADBEEF);
        chk("single_rlast_const", 64'(rlast_o), 64'd1);
        rready_i = 1'b1;
        cyc();
        rready_i = 1'b0;
        chk("single_arready_n3", 64'(arready_o), 64'd1);

        for (int i = 0; i < 6; i++) begin
            do_burst(vecs[i].name, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst,
                     vecs[i].stall_beat, vecs[i].stall_cyc, 1'b0, vecs[i].exp_first);
        end

        // Reset mid-burst: assert during RESP of beat 1 of a len=3 burst
        arid_i = 8'h77; araddr_i = 32'h200; arlen_i = 4'd3; arburst_i = 2'b01; arvalid_i = 1'b1;
        cyc();
        arvalid_i = 1'b0;
        cyc();
        rready_i = 1'b1;
        cyc();
        rready_i = 1'b0;
        cyc();
        chk("rst_pre_rvalid", 64'(rvalid_o), 64'd1);
        chk("rst_pre_rid", 64'(rid_o), 64'h77);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_mid_cs", 64'(sram_cs_o), 64'd0);
        chk_idle("rst_mid", 14'h0);
        cyc();
        @(negedge clk);
        rst = 1'b1;
        rready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_after_rvalid", 64'(rvalid_o), 64'd0);
            chk("rst_after_arready", 64'(arready_o), 64'd1);
        end
        rready_i = 1'b0;

        // Back-to-back: arvalid held high; second AR taken one cycle after last handshake
        arid_i = 8'h81; araddr_i = 32'h300; arlen_i = 4'd1; arburst_i = 2'b01; arvalid_i = 1'b1;
        rready_i = 1'b1;
        cyc();
        arid_i = 8'h92; araddr_i = 32'h500; arlen_i = 4'd0;
        chk("b2b_fetch0_arready", 64'(arready_o), 64'd0);
        cyc();
        chk_beat("b2b_b0", 8'h81, 14'h0C0, 2'b00, 1'b0);
        cyc();
        chk("b2b_fetch1_arready", 64'(arready_o), 64'd0);
        cyc();
        chk_beat("b2b_b1", 8'h81, 14'h0C1, 2'b00, 1'b1);
        cyc();
        chk("b2b_idle_arready", 64'(arready_o), 64'd1);
        chk("b2b_idle_rvalid", 64'(rvalid_o), 64'd0);
        cyc();
        arvalid_i = 1'b0;
        chk("b2b_fetch2_a", 64'(sram_a_o), 64'h140);
        chk("b2b_fetch2_arready", 64'(arready_o), 64'd0);
        cyc();
        chk_beat("b2b_b2", 8'h92, 14'h140, 2'b00, 1'b1);
        cyc();
        rready_i = 1'b0;
        chk_idle("b2b_end", 14'h140);

        // Randomized bursts against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  b;
            a = $urandom;
            b = 2'($urandom_range(0, 3));
            do_burst("rnd", 8'($urandom), a, 4'($urandom), b, -1, 0, 1'b1, a[15:2]);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                cyc();
                chk("rnd_gap_rvalid", 64'(rvalid_o), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
